// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel servo PWM; commands and enables take effect only at frame wrap.
// Define SERVO_PWM_SLEW_EN to limit the per-frame change of each applied command to SLEW_STEP.
module servo_pwm_multi #(
  parameter int N_CH        = 4,
  parameter int PERIOD_CLKS = 1000000,
  parameter int MIN_CLKS    = 50000,
  parameter int MAX_SPAN    = 50000,
  parameter int CTRL_W      = 16,
  parameter int SLEW_STEP   = 500
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CTRL_W-1:0] wr_data,
  input  logic [N_CH-1:0]   enable,
  output logic [N_CH-1:0]   servo,
  output logic              frame_start
);
  localparam int LIM = (PERIOD_CLKS > MIN_CLKS + MAX_SPAN) ? PERIOD_CLKS : MIN_CLKS + MAX_SPAN + 1;
  localparam int CW  = ($clog2(LIM) > 20) ? $clog2(LIM) : 20;
  localparam int DW  = (CTRL_W > CW) ? CTRL_W : CW;
  logic [CW-1:0]   cnt, wdat;
  logic [CW-1:0]   tgt [N_CH];
  logic [CW-1:0]   app [N_CH];
  logic [CW-1:0]   nxt [N_CH];
  logic [N_CH-1:0] en_l;
  logic            wrap;
  assign wrap = cnt == CW'(PERIOD_CLKS - 1);
  assign wdat = (DW'(wr_data) > DW'(MAX_SPAN)) ? CW'(MAX_SPAN) : CW'(wr_data);
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
`ifdef SERVO_PWM_SLEW_EN
      nxt[i] = (tgt[i] > app[i])
             ? ((tgt[i] - app[i] > CW'(SLEW_STEP)) ? app[i] + CW'(SLEW_STEP) : tgt[i])
             : ((app[i] - tgt[i] > CW'(SLEW_STEP)) ? app[i] - CW'(SLEW_STEP) : tgt[i]);
`else
      nxt[i] = tgt[i];
`endif
    end
  end
  // applied[] reads the pre-write target on the wrap cycle, so a wrap-cycle write lands one frame later
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      frame_start <= 1'b0;
      en_l        <= '0;
      servo       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        tgt[i] <= '0;
        app[i] <= '0;
      end
    end else begin
      cnt         <= wrap ? '0 : cnt + CW'(1);
      frame_start <= cnt == '0;
      if (wrap) en_l <= enable;
      for (int i = 0; i < N_CH; i++) begin
        if (wr_en && wr_ch == 4'(i)) tgt[i] <= wdat;
        if (wrap) app[i] <= nxt[i];
        servo[i] <= en_l[i] && (cnt < CW'(MIN_CLKS) + app[i]);
      end
    end
  end
endmodule
